// File: rtl/uart_pkt_rx.sv
// Packet deframer behind the UART RX FIFO: SOF, LEN, payload, CHK -> buffered payload stream.
// Optional inter-byte timeout enabled with `define UART_PKT_TIMEOUT_EN.
module uart_pkt_rx #(
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] SOF     = 8'h7E,
  parameter int         TMO_CYC = 65536,
  parameter int         TMO_W   = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  input  logic       rx_err,
  output logic       rd_uart,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [2:0] err_code,
  output logic       busy
);
  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [7:0] MAXL  = (DEPTH > 255) ? 8'd255 : 8'(DEPTH);

  if (ADDR_W < 1 || ADDR_W > 8) begin : g_addr_chk
    $error("ADDR_W out of range");
  end
  if (TMO_CYC >= (1 << TMO_W)) begin : g_tmo_chk
    $error("TMO_W too narrow for TMO_CYC");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_CHK, S_DRAIN} state_t;

  state_t     state, state_n;
  logic [7:0] len, len_n, sum, sum_n, wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic       ok_n, err_n, wr_en;
  logic [2:0] code_n;
  logic       pop;
  logic [7:0] mem [DEPTH];

  // Pops gated by reset so the FIFO is untouched while reset is held.
  assign pop     = reset & ~rx_empty & (state != S_DRAIN);
  assign rd_uart = pop;
  assign m_valid = reset & (state == S_DRAIN);
  assign m_last  = m_valid & (rd_ptr == len - 8'd1);
  assign m_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign busy    = reset & (state != S_IDLE);

`ifdef UART_PKT_TIMEOUT_EN
  logic [TMO_W-1:0] tmo, tmo_n;
`endif

  always_comb begin
    state_n  = state;
    len_n    = len;
    sum_n    = sum;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    code_n   = err_code;
    wr_en    = 1'b0;
    case (state)
      S_IDLE: if (pop && r_data == SOF && !rx_err) state_n = S_LEN;
      S_LEN: if (pop) begin
        if (rx_err) begin
          err_n = 1'b1; code_n = 3'd3; state_n = S_IDLE;
        end else if (r_data == 8'd0 || r_data > MAXL) begin
          err_n = 1'b1; code_n = 3'd1; state_n = S_IDLE;
        end else begin
          len_n = r_data; sum_n = r_data; wr_ptr_n = 8'd0; state_n = S_PAY;
        end
      end
      S_PAY: if (pop) begin
        if (rx_err) begin
          err_n = 1'b1; code_n = 3'd3; state_n = S_IDLE;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + 8'd1;
          sum_n    = sum + r_data;
          if (wr_ptr == len - 8'd1) state_n = S_CHK;
        end
      end
      S_CHK: if (pop) begin
        if (rx_err) begin
          err_n = 1'b1; code_n = 3'd3; state_n = S_IDLE;
        end else if (r_data != sum) begin
          err_n = 1'b1; code_n = 3'd2; state_n = S_IDLE;
        end else begin
          ok_n = 1'b1; rd_ptr_n = 8'd0; state_n = S_DRAIN;
        end
      end
      S_DRAIN: if (m_ready) begin
        rd_ptr_n = rd_ptr + 8'd1;
        if (rd_ptr == len - 8'd1) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef UART_PKT_TIMEOUT_EN
    tmo_n = '0;
    if (state == S_LEN || state == S_PAY || state == S_CHK) begin
      if (!pop) begin
        if (tmo == TMO_W'(TMO_CYC - 1)) begin
          err_n = 1'b1; code_n = 3'd4; state_n = S_IDLE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      len      <= '0;
      sum      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
`ifdef UART_PKT_TIMEOUT_EN
      tmo      <= '0;
`endif
    end else begin
      state    <= state_n;
      len      <= len_n;
      sum      <= sum_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      pkt_ok   <= ok_n;
      pkt_err  <= err_n;
      err_code <= code_n;
`ifdef UART_PKT_TIMEOUT_EN
      tmo      <= tmo_n;
`endif
    end
  end

  // Payload RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= r_data;
  end
endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: FIFO model, frame-level parser model, per-cycle compare.
module tb_uart_pkt_rx;
  localparam int         MAXL = 16;
  localparam logic [7:0] SOF  = 8'h7E;

  logic       clk = 1'b0, reset = 1'b0;
  logic       rx_empty = 1'b1, rx_err = 1'b0, m_ready = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart, m_valid, m_last, pkt_ok, pkt_err, busy;
  logic [7:0] m_data;
  logic [2:0] err_code;

  uart_pkt_rx #(.ADDR_W(4), .SOF(8'h7E), .TMO_CYC(100), .TMO_W(17)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rx_err(rx_err),
    .rd_uart(rd_uart), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0, last_pop_cyc = 0, err_cyc = 0;
  logic prev_pop = 1'b0, hs_last_prev = 1'b0, pop_q = 1'b0;

  logic [7:0] fifo_d[$];
  bit         fifo_e[$];
  logic [7:0] stim_b[$];
  bit         stim_e[$];
  logic [8:0] exp_data[$];   // {last, byte}
  int         exp_ev[$];     // 0 = pkt_ok, otherwise expected err_code

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nvec++; nerr++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Frame-level reference: scan the byte stream with plain indices.
  function automatic void model();
    int i = 0;
    while (i < stim_b.size()) begin
      logic [7:0] l, s;
      logic [7:0] pl[$];
      bit abort;
      if (stim_b[i] != SOF || stim_e[i]) begin i++; continue; end
      i++;
      if (i >= stim_b.size()) break;
      if (stim_e[i]) begin exp_ev.push_back(3); i++; continue; end
      l = stim_b[i];
      i++;
      if (l == 0 || int'(l) > MAXL) begin exp_ev.push_back(1); continue; end
      s = l; abort = 0;
      for (int k = 0; k < int'(l); k++) begin
        if (i >= stim_b.size()) begin abort = 1; break; end
        if (stim_e[i]) begin exp_ev.push_back(3); i++; abort = 1; break; end
        pl.push_back(stim_b[i]); s = s + stim_b[i]; i++;
      end
      if (abort || i >= stim_b.size()) continue;
      if (stim_e[i]) exp_ev.push_back(3);
      else if (stim_b[i] != s) exp_ev.push_back(2);
      else begin
        exp_ev.push_back(0);
        foreach (pl[k]) exp_data.push_back({k == pl.size() - 1, pl[k]});
      end
      i++;
    end
  endfunction

  task automatic add(input logic [7:0] b, input bit e = 0);
    stim_b.push_back(b); stim_e.push_back(e);
  endtask

  task automatic push_only();
    foreach (stim_b[k]) begin fifo_d.push_back(stim_b[k]); fifo_e.push_back(stim_e[k]); end
    stim_b.delete(); stim_e.delete();
  endtask

  task automatic go();
    model();
    push_only();
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (fifo_d.size() == 0 && !busy && !pkt_ok && !pkt_err &&
          exp_data.size() == 0 && exp_ev.size() == 0) break;
    end
    if (k == 1000) fail(nm);
  endtask

  // FIFO model: first-word-fall-through, popped on the edge after rd_uart is seen.
  always @(posedge clk) begin
    if (pop_q) begin void'(fifo_d.pop_front()); void'(fifo_e.pop_front()); end
    #1;
    rx_empty = (fifo_d.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo_d[0];
    rx_err   = rx_empty ? 1'b0  : fifo_e[0];
  end

  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (reset) begin
      if (m_valid && m_ready) begin
        if (exp_data.size() == 0) fail("extra_beat");
        else begin
          e = exp_data.pop_front();
          chk("m_data", {24'd0, m_data}, {24'd0, e[7:0]});
          chk("m_last", {31'd0, m_last}, {31'd0, e[8]});
        end
      end
      if (pkt_ok || pkt_err) begin
        chk("ok_err_excl", {31'd0, pkt_ok & pkt_err}, 32'd0);
        if (exp_ev.size() == 0) fail("extra_event");
        else chk("event_code", pkt_ok ? 32'd0 : {29'd0, err_code}, exp_ev.pop_front());
        if (!prev_pop && !(pkt_err && err_code == 3'd4)) chk("pulse_after_pop", 32'd0, 32'd1);
        if (pkt_err) err_cyc = cyc;
      end
      if (pkt_ok) chk("ok_with_valid", {31'd0, m_valid}, 32'd1);
      if (m_valid) chk("no_pop_in_drain", {31'd0, rd_uart}, 32'd0);
      if (hs_last_prev) chk("idle_after_last", {30'd0, busy, m_valid}, 32'd0);
    end
    prev_pop     = rd_uart;
    pop_q        = rd_uart;
    hs_last_prev = reset && m_valid && m_ready && m_last;
    if (rd_uart) last_pop_cyc = cyc;
  end

  initial begin
    int k;
    logic [7:0] lit[3];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {26'd0, rd_uart, m_valid, m_last, pkt_ok, pkt_err, busy}, 32'd0);
    chk("rst_code", {29'd0, err_code}, 32'd0);
    @(posedge clk); #2 reset = 1'b1;

    // 1: good 3-byte frame, zero-wait drain
    add(8'h7E); add(8'h03); add(8'h11); add(8'h22); add(8'h33); add(8'h69);
    go();
    chk("model_t1_n", exp_data.size(), 32'd3);
    chk("model_t1_last", {23'd0, exp_data[2]}, {23'd0, 9'h133});
    k = 0;
    do @(negedge clk); while (!pkt_ok && ++k < 100);
    if (!pkt_ok) fail("t1_pkt_ok");
    lit[0] = 8'h11; lit[1] = 8'h22; lit[2] = 8'h33;
    for (int j = 0; j < 3; j++) begin
      chk("t1_valid", {31'd0, m_valid}, 32'd1);
      chk("t1_data", {24'd0, m_data}, {24'd0, lit[j]});
      chk("t1_last", {31'd0, m_last}, (j == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("t1_busy_fall", {30'd0, busy, m_valid}, 32'd0);
    wait_done("t1_done");

    // 2: junk byte, bad checksum, then good 1-byte frame
    add(8'h55); add(8'h7E); add(8'h02); add(8'hAA); add(8'hBB); add(8'h00);
    add(8'h7E); add(8'h01); add(8'h55); add(8'h56);
    go();
    chk("model_t2_ev0", exp_ev[0], 32'd2);
    chk("model_t2_ev1", exp_ev[1], 32'd0);
    wait_done("t2_done");

    // 3: zero length, oversize length, then good frame
    add(8'h7E); add(8'h00); add(8'h7E); add(8'h11);
    add(8'h7E); add(8'h01); add(8'h55); add(8'h56);
    go();
    chk("model_t3_ev", {exp_ev[0][7:0], exp_ev[1][7:0], exp_ev[2][7:0]}, 32'h010100);
    wait_done("t3_done");

    // 4: backpressure with a second frame waiting in the FIFO
    add(8'h7E); add(8'h03); add(8'h11); add(8'h22); add(8'h33); add(8'h69);
    add(8'h7E); add(8'h02); add(8'h44); add(8'h55); add(8'h9B);
    go();
    k = 0;
    do @(negedge clk); while (!m_valid && ++k < 100);
    if (!m_valid) fail("t4_first_valid");
    chk("t4_first", {24'd0, m_data}, 32'h11);
    @(posedge clk); #2 m_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("t4_stall", {22'd0, m_valid, rd_uart, m_data}, {22'd0, 2'b10, 8'h22});
    end
    @(posedge clk); #2 m_ready = 1'b1;
    wait_done("t4_done");

    // 5: parity error on 2nd payload byte, tail discarded, then good frame
    add(8'h7E); add(8'h04); add(8'hA1); add(8'hA2, 1); add(8'hA3); add(8'hA4); add(8'hB0);
    add(8'h7E); add(8'h01); add(8'h55); add(8'h56);
    go();
    chk("model_t5_ev0", exp_ev[0], 32'd3);
    wait_done("t5_done");

`ifdef UART_PKT_TIMEOUT_EN
    // 6a: timeout after a stalled payload
    add(8'h7E); add(8'h02); add(8'hAA);
    go();
    exp_ev.push_back(4);
    k = 0;
    do @(negedge clk); while (!pkt_err && ++k < 300);
    #1;
    if (!pkt_err) fail("t6_tmo");
    else begin
      chk("t6_code", {29'd0, err_code}, 32'd4);
      chk("t6_tmo_cycles", err_cyc - last_pop_cyc, 32'd101);
    end
    wait_done("t6a_done");
`endif

    // 6b: reset mid-payload aborts silently
    add(8'h7E); add(8'h03); add(8'h01); add(8'h02);
    push_only();
    repeat (10) @(negedge clk);
    chk("t6_in_pay", {31'd0, busy}, 32'd1);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("t6_rst_outs", {23'd0, rd_uart, m_valid, m_last, pkt_ok, pkt_err, busy, err_code}, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    add(8'h7E); add(8'h01); add(8'h55); add(8'h56);
    go();
    wait_done("t6b_done");

    chk("left_data", exp_data.size(), 32'd0);
    chk("left_ev", exp_ev.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_pkt_rx.md
Name: uart_pkt_rx

Overview:
Receive-side packet deframer that sits directly downstream of the parity UART's RX FIFO. It pops bytes using the FIFO's first-word-fall-through read handshake and assembles length-delimited frames of the form SOF, LEN, payload, CHK. Each payload is held in an internal buffer. A payload is released on a valid/ready byte stream only after its checksum and parity checks pass; otherwise the frame is discarded and an error is reported.

Parameters:
ADDR_W, 4, buffer address bits; max payload MAXL = min(2^ADDR_W, 255); legal range 1..8
SOF, 8'h7E, start-of-frame byte
TMO_CYC, 65536, inter-byte timeout in clk cycles (used only with the optional feature)
TMO_W, 17, width of the timeout counter; must satisfy 2^TMO_W > TMO_CYC

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx_empty  in  1  UART RX FIFO empty
r_data  in  8  UART RX FIFO head byte; valid whenever rx_empty=0
rx_err  in  1  UART parity error, sampled in the pop cycle
rd_uart  out  1  one-cycle pop strobe to the UART RX FIFO
m_data  out  8  payload byte out
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts the byte
m_last  out  1  marks the final payload byte (qualified by m_valid)
pkt_ok  out  1  one-cycle pulse: frame accepted
pkt_err  out  1  one-cycle pulse: frame rejected
err_code  out  3  1=LEN, 2=CHK, 3=PAR, 4=TMO; updated on pkt_err, otherwise held
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset:
  - state goes to IDLE; rd_uart, m_valid, m_last, pkt_ok, pkt_err, busy = 0; err_code = 0; all pointers and counters = 0.
  - Buffer RAM contents are not cleared.
  - Reset asserted mid-frame or mid-drain aborts with no pkt_ok/pkt_err pulse.
- Pop rule:
  - In IDLE, LEN, PAY and CHK: rd_uart = ~rx_empty, driven combinationally.
  - r_data and rx_err are consumed in the same cycle as the pop.
  - At most one byte per cycle.
  - In DRAIN, rd_uart is held at 0, so the FIFO absorbs backpressure.
- States:
  - IDLE:
    - popped byte == SOF with rx_err=0 -> LEN.
    - Any other byte, including SOF with rx_err=1, is discarded silently.
  - LEN:
    - rx_err=1 -> pkt_err, code 3, go to IDLE.
    - byte == 0 or byte > MAXL -> pkt_err, code 1, go to IDLE.
    - otherwise latch len, set sum = byte, wr_ptr = 0 -> PAY.
  - PAY:
    - each pop writes buf[wr_ptr], increments wr_ptr, and does sum += byte (mod 256).
    - rx_err=1 -> pkt_err, code 3, go to IDLE immediately.
    - after len bytes -> CHK.
    - A SOF value inside the payload is treated as data.
  - CHK:
    - rx_err=1 -> code 3.
    - byte != sum -> code 2.
    - either error: pkt_err and go to IDLE.
    - match -> DRAIN with rd_ptr = 0.
  - DRAIN:
    - m_valid = 1, m_data = buf[rd_ptr] (combinational read), m_last = (rd_ptr == len-1).
    - On m_valid & m_ready, rd_ptr increments.
    - The handshake on the last byte -> IDLE; m_valid = 0 in the next cycle.
- Timing:
  - The CHK byte is popped in cycle t.
  - pkt_ok pulses in cycle t+1, and the first m_valid is also in t+1.
  - Error pulses occur in the cycle after the offending pop.
  - First pop of the next frame is possible in the cycle after the last handshake.
  - Zero-wait drain: len cycles.
- Buffer is written only in PAY. A new frame's writes never overlap a drain because DRAIN blocks pops.
- busy = (state != IDLE).

Optional Feature:
UART_PKT_TIMEOUT_EN
- Defined:
  - In LEN, PAY and CHK, a TMO_W-bit counter increments every cycle with no pop.
  - The counter clears on every pop and on entry to LEN.
  - Reaching TMO_CYC -> pkt_err, code 4, go to IDLE, counter cleared.
  - The counter is inactive in IDLE and DRAIN.
- Undefined:
  - The counter logic is absent.
  - A partial frame waits indefinitely.
  - Code 4 is never produced.

Test Plan:
1. Bytes 7E 03 11 22 33 69 -> pkt_ok once; m_data 11, 22, 33 on consecutive cycles with m_ready=1; m_last only with 33; busy falls after the 33 handshake.
2. Bytes 55 7E 02 AA BB 00 (expected CHK 67) -> leading 55 discarded; pkt_err with err_code=2; m_valid never asserted. Then 7E 01 55 56 -> pkt_ok, m_data=55.
3. LEN byte 00 -> code 1. LEN byte 11 with ADDR_W=4 -> code 1; the following bytes 7E 01 55 56 are accepted normally.
4. Good 3-byte frame with m_ready low for 20 cycles after the first byte, and a second frame queued in the FIFO -> rd_uart=0 throughout DRAIN; m_data holds 22 while stalled; the second frame is delivered intact afterwards.
5. rx_err=1 on the 2nd payload byte of 7E 04 ... -> pkt_err code 3 in the next cycle; state returns to IDLE; the remaining bytes are discarded until the next 7E.
6. With UART_PKT_TIMEOUT_EN, TMO_CYC=100: send 7E 02 AA, then silence -> pkt_err code 4 exactly 100 idle cycles after the AA pop. Separately, assert reset low mid-PAY -> all outputs 0 and no pulses; the next good frame passes.
